// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: memory access encodings and queued store entry shared with the data memory controller
package store_buffer_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [1:0]      mem_type;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: store/load requests from the memory stage and the single data memory port
interface store_buffer_if import store_buffer_pkg::*; #(parameter int AW = XLEN);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [AW-1:0] st_data;
  logic [1:0]    st_type;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [1:0]    ld_type;
  logic          ld_sign;
  logic          ld_stall;
  logic          mem_write_en;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_write_data;
  logic [1:0]    mem_type;
  logic          mem_sign;
  logic          empty;
  modport slave (
    input  st_valid, st_addr, st_data, st_type, ld_valid, ld_addr, ld_type, ld_sign,
    output st_ready, ld_stall, mem_write_en, mem_addr, mem_write_data, mem_type, mem_sign, empty
  );
  modport master (
    output st_valid, st_addr, st_data, st_type, ld_valid, ld_addr, ld_type, ld_sign,
    input  st_ready, ld_stall, mem_write_en, mem_addr, mem_write_data, mem_type, mem_sign, empty
  );
endinterface

// File: rtl/store_buffer_sb_addr_match.sv
// store_buffer_sb_addr_match: word-address compare of a load against every valid queued store
module store_buffer_sb_addr_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][AW-3:0] words,
  input  logic [AW-3:0]            ld_word,
  output logic                     match,
  output logic [DEPTH-1:0]         match_vec
);
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match_vec[i] = valid[i] && (words[i] == ld_word);
  end
  assign match = |match_vec;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO that drains to data memory whenever no load owns the port
module store_buffer import store_buffer_pkg::*; #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = XLEN
) (
  input logic         clk_i,
  input logic         rst_i,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  sb_entry_t                          ent [DEPTH];
  sb_entry_t                          hd;
  logic [DEPTH-1:0]                   vld;
  logic [DEPTH-1:0][ADDR_WIDTH-3:0]   words;
  logic [DEPTH-1:0]                   match_vec_unused;
  logic [PW-1:0]                      head, tail;
  logic [PW:0]                        count;
  logic                               full, empty, match, push, pop, ld_go;
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    assign words[w] = ent[w].addr[ADDR_WIDTH-1:2];
  end
  store_buffer_sb_addr_match #(.DEPTH(DEPTH), .AW(ADDR_WIDTH)) u_match (
    .valid     (vld),
    .words     (words),
    .ld_word   (sb.ld_addr[ADDR_WIDTH-1:2]),
    .match     (match),
    .match_vec (match_vec_unused)
  );
  assign full  = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign push  = rst_i && sb.st_valid && !full;
  assign ld_go = rst_i && sb.ld_valid && !match;
  // a stalled load yields the port so its conflicting store can drain
  assign pop   = rst_i && !ld_go && !empty;
  assign hd    = ent[head];
  assign sb.st_ready       = !rst_i || !full;
  assign sb.empty          = !rst_i || empty;
  assign sb.ld_stall       = rst_i && sb.ld_valid && match;
  assign sb.mem_write_en   = pop;
  assign sb.mem_addr       = pop ? hd.addr : rst_i ? sb.ld_addr : '0;
  assign sb.mem_write_data = pop ? hd.data : '0;
  assign sb.mem_type       = pop ? hd.mem_type : rst_i ? sb.ld_type : MEM_BYTE;
  assign sb.mem_sign       = ld_go && sb.ld_sign;
  always_ff @(posedge clk_i) begin
    if (push) ent[tail] <= '{addr: sb.st_addr, data: sb.st_data, mem_type: sb.st_type};
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PW'(1);
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PW'(1);
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios for the posted-write store buffer
module tb_store_buffer;
  import store_buffer_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   allow_dual = 1'b0;
  always #5 clk_i = ~clk_i;
  store_buffer_if bus ();
  store_buffer #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sb    (bus)
  );
  // the memory stage issues one op per cycle; scenarios that hold the port open with a load lift this
  always @(posedge clk_i)
    if (rst_i && !allow_dual)
      assert (!(bus.st_valid && bus.ld_valid)) else $error("FAIL st_ld_overlap store and load in same cycle");
  task automatic idle();
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_type = MEM_BYTE;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_type = MEM_BYTE; bus.ld_sign = 1'b0;
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    bus.st_valid = 1'b1; bus.st_addr = a; bus.st_data = d; bus.st_type = t;
  endtask
  task automatic ld(input logic [31:0] a, input logic [1:0] t, input logic s);
    bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_type = t; bus.ld_sign = s;
  endtask
  task automatic test_reset();
    idle();
    rst_i = 1'b0;
    st(32'h55, 32'h66, MEM_WORD);
    repeat (2) begin
      @(negedge clk_i); #1;
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
      checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got=%b exp=1", bus.st_ready); end
      checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", bus.mem_write_en); end
      checks++; if (bus.ld_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.ld_stall); end
      checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
    end
    @(negedge clk_i); rst_i = 1'b1; idle(); #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_no_capture_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_no_capture_wen got=%b exp=0", bus.mem_write_en); end
  endtask
  task automatic test_store_idle();
    @(negedge clk_i); st(32'h100, 32'hDEADBEEF, MEM_WORD); #1;
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL sw_ready got=%b exp=1", bus.st_ready); end
    checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL sw_same_cycle_wen got=%b exp=0", bus.mem_write_en); end
    @(negedge clk_i); idle(); #1;
    checks++; if (bus.mem_write_en !== 1'b1) begin errors++; $display("FAIL sw_drain_wen got=%b exp=1", bus.mem_write_en); end
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL sw_drain_addr got=%h exp=100", bus.mem_addr); end
    checks++; if (bus.mem_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_drain_data got=%h exp=deadbeef", bus.mem_write_data); end
    checks++; if (bus.mem_type !== MEM_WORD) begin errors++; $display("FAIL sw_drain_type got=%b exp=10", bus.mem_type); end
    checks++; if (bus.mem_sign !== 1'b0) begin errors++; $display("FAIL sw_drain_sign got=%b exp=0", bus.mem_sign); end
    @(negedge clk_i); #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL sw_after_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL sw_after_wen got=%b exp=0", bus.mem_write_en); end
  endtask
  task automatic test_fill();
    allow_dual = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); st(32'h10 + 32'(4*i), 32'hA0 + 32'(i), MEM_BYTE); ld(32'h800, MEM_WORD, 1'b0); #1;
      checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got=%b exp=1", i, bus.st_ready); end
      checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL fill_wen_%0d got=%b exp=0", i, bus.mem_write_en); end
    end
    @(negedge clk_i); st(32'h20, 32'hEE, MEM_BYTE); #1;
    checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", bus.st_ready); end
    checks++; if (bus.mem_addr !== 32'h800) begin errors++; $display("FAIL fill_load_addr got=%h exp=800", bus.mem_addr); end
    @(negedge clk_i); idle(); allow_dual = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.mem_write_en !== 1'b1) begin errors++; $display("FAIL fill_drain_wen_%0d got=%b exp=1", i, bus.mem_write_en); end
      checks++; if (bus.mem_addr !== 32'h10 + 32'(4*i)) begin errors++; $display("FAIL fill_drain_addr_%0d got=%h exp=%h", i, bus.mem_addr, 32'h10 + 32'(4*i)); end
      checks++; if (bus.mem_write_data !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL fill_drain_data_%0d got=%h exp=%h", i, bus.mem_write_data, 32'hA0 + 32'(i)); end
      checks++; if (bus.mem_type !== MEM_BYTE) begin errors++; $display("FAIL fill_drain_type_%0d got=%b exp=00", i, bus.mem_type); end
      @(negedge clk_i);
    end
    #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fill_dropped_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL fill_dropped_wen got=%b exp=0", bus.mem_write_en); end
  endtask
  task automatic test_hazard();
    @(negedge clk_i); st(32'h202, 32'hABCD, MEM_HALF);
    @(negedge clk_i); bus.st_valid = 1'b0; ld(32'h200, MEM_WORD, 1'b1); #1;
    checks++; if (bus.ld_stall !== 1'b1) begin errors++; $display("FAIL haz_stall got=%b exp=1", bus.ld_stall); end
    checks++; if (bus.mem_write_en !== 1'b1) begin errors++; $display("FAIL haz_drain_wen got=%b exp=1", bus.mem_write_en); end
    checks++; if (bus.mem_addr !== 32'h202) begin errors++; $display("FAIL haz_drain_addr got=%h exp=202", bus.mem_addr); end
    checks++; if (bus.mem_write_data !== 32'hABCD) begin errors++; $display("FAIL haz_drain_data got=%h exp=abcd", bus.mem_write_data); end
    checks++; if (bus.mem_type !== MEM_HALF) begin errors++; $display("FAIL haz_drain_type got=%b exp=01", bus.mem_type); end
    checks++; if (bus.mem_sign !== 1'b0) begin errors++; $display("FAIL haz_drain_sign got=%b exp=0", bus.mem_sign); end
    @(negedge clk_i); #1;
    checks++; if (bus.ld_stall !== 1'b0) begin errors++; $display("FAIL haz_release_stall got=%b exp=0", bus.ld_stall); end
    checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL haz_load_wen got=%b exp=0", bus.mem_write_en); end
    checks++; if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL haz_load_addr got=%h exp=200", bus.mem_addr); end
    checks++; if (bus.mem_type !== MEM_WORD) begin errors++; $display("FAIL haz_load_type got=%b exp=10", bus.mem_type); end
    checks++; if (bus.mem_sign !== 1'b1) begin errors++; $display("FAIL haz_load_sign got=%b exp=1", bus.mem_sign); end
    @(negedge clk_i); idle(); #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL haz_empty got=%b exp=1", bus.empty); end
  endtask
  task automatic test_bypass();
    @(negedge clk_i); st(32'h300, 32'h12345678, MEM_WORD);
    @(negedge clk_i); bus.st_valid = 1'b0; ld(32'h400, MEM_WORD, 1'b0); #1;
    checks++; if (bus.ld_stall !== 1'b0) begin errors++; $display("FAIL byp_stall got=%b exp=0", bus.ld_stall); end
    checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL byp_wen got=%b exp=0", bus.mem_write_en); end
    checks++; if (bus.mem_addr !== 32'h400) begin errors++; $display("FAIL byp_addr got=%h exp=400", bus.mem_addr); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL byp_pending got=%b exp=0", bus.empty); end
    @(negedge clk_i); idle(); #1;
    checks++; if (bus.mem_write_en !== 1'b1) begin errors++; $display("FAIL byp_drain_wen got=%b exp=1", bus.mem_write_en); end
    checks++; if (bus.mem_addr !== 32'h300) begin errors++; $display("FAIL byp_drain_addr got=%h exp=300", bus.mem_addr); end
    checks++; if (bus.mem_write_data !== 32'h12345678) begin errors++; $display("FAIL byp_drain_data got=%h exp=12345678", bus.mem_write_data); end
    @(negedge clk_i); #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL byp_empty got=%b exp=1", bus.empty); end
  endtask
  task automatic test_push_pop_wrap();
    @(negedge clk_i); idle(); rst_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); st(32'h500, 32'h500 ^ 32'hFFFF0000, MEM_WORD); #1;
    checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL wrap_first_wen got=%b exp=0", bus.mem_write_en); end
    @(negedge clk_i); st(32'h504, 32'h504 ^ 32'hFFFF0000, MEM_WORD); #1;
    checks++; if (bus.mem_addr !== 32'h500 || bus.mem_write_en !== 1'b1) begin errors++; $display("FAIL wrap_drain0 got=%h/%b exp=500/1", bus.mem_addr, bus.mem_write_en); end
    @(negedge clk_i); allow_dual = 1'b1; st(32'h508, 32'h508 ^ 32'hFFFF0000, MEM_WORD); ld(32'h900, MEM_WORD, 1'b0); #1;
    checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL wrap_hold_wen got=%b exp=0", bus.mem_write_en); end
    @(negedge clk_i); bus.ld_valid = 1'b0; allow_dual = 1'b0; st(32'h50C, 32'h50C ^ 32'hFFFF0000, MEM_WORD); #1;
    checks++; if (bus.mem_addr !== 32'h504 || bus.mem_write_en !== 1'b1) begin errors++; $display("FAIL wrap_pushpop_drain got=%h/%b exp=504/1", bus.mem_addr, bus.mem_write_en); end
    @(negedge clk_i); allow_dual = 1'b1; st(32'h510, 32'h510 ^ 32'hFFFF0000, MEM_WORD); ld(32'h900, MEM_WORD, 1'b0); #1;
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_cnt2 got=%b exp=1", bus.st_ready); end
    @(negedge clk_i); st(32'h514, 32'h514 ^ 32'hFFFF0000, MEM_WORD); #1;
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_cnt3 got=%b exp=1", bus.st_ready); end
    @(negedge clk_i); bus.st_valid = 1'b0; #1;
    checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL wrap_full got=%b exp=0", bus.st_ready); end
    @(negedge clk_i); idle(); allow_dual = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.mem_addr !== 32'h508 + 32'(4*i) || bus.mem_write_en !== 1'b1) begin errors++; $display("FAIL wrap_order_%0d got=%h/%b exp=%h/1", i, bus.mem_addr, bus.mem_write_en, 32'h508 + 32'(4*i)); end
      checks++; if (bus.mem_write_data !== ((32'h508 + 32'(4*i)) ^ 32'hFFFF0000)) begin errors++; $display("FAIL wrap_data_%0d got=%h exp=%h", i, bus.mem_write_data, (32'h508 + 32'(4*i)) ^ 32'hFFFF0000); end
      @(negedge clk_i);
    end
    #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", bus.empty); end
  endtask
  initial begin
    test_reset();
    test_store_idle();
    test_fill();
    test_hazard();
    test_bypass();
    test_push_pop_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
